pulse_period_mon: RTL and testbench

PULSE_PERIOD_MON -- requirements
Module: pulse_period_mon

---
 rtl/pulse_period_mon.sv | 153 +++++++++++++++
 tb/tb_pulse_period_mon.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_mon.sv
// Periodic pulse monitor: measures the distance between sig_in pulses, locks after LOCK_N good
// intervals and flags early/late pulses. Define PULSE_MON_STICKY_ERR_EN to make err sticky until rst.
module pulse_period_mon #(
    parameter int PERIOD = 20001,
    parameter int TOL    = 2,
    parameter int LOCK_N = 3,
    parameter int CBITS  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic             locked,
    output logic             early,
    output logic             late,
    output logic             err,
    output logic [7:0]       miss_cnt,
    output logic [CBITS-1:0] interval
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam int GBITS = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

    localparam logic [CBITS-1:0] LO_LIM  = CBITS'(PERIOD - TOL);
    localparam logic [CBITS-1:0] HI_LIM  = CBITS'(PERIOD + TOL);
    localparam logic [CBITS-1:0] CNT_MAX = {CBITS{1'b1}};
    localparam logic [CBITS-1:0] CNT_ONE = CBITS'(1);
    localparam logic [GBITS-1:0] GOOD_TARGET = GBITS'(LOCK_N);
    localparam logic [GBITS-1:0] GOOD_ONE    = GBITS'(1);

    logic [1:0]       r_state;
    logic [CBITS-1:0] r_cnt;
    logic [GBITS-1:0] r_good;
    logic             r_locked;
    logic             r_early;
    logic             r_late;
    logic             r_err;
    logic [7:0]       r_miss;
    logic [CBITS-1:0] r_interval;

    logic             w_tracking;
    logic             w_pulse_chk;
    logic             w_early_ev;
    logic             w_late_ev;
    logic             w_good_ev;
    logic             w_miss_ev;
    logic [GBITS-1:0] w_good_inc;
    logic [1:0]       w_state_nxt;
    logic [GBITS-1:0] w_good_nxt;

    assign w_tracking  = (r_state == TRACK) || (r_state == LOCKED);
    assign w_pulse_chk = sig_in & w_tracking;
    assign w_early_ev  = w_pulse_chk & (r_cnt < LO_LIM);
    assign w_good_ev   = w_pulse_chk & (r_cnt >= LO_LIM) & (r_cnt <= HI_LIM);
    // A pulse landing exactly on PERIOD+TOL is good, so late needs the pulse to be absent.
    assign w_late_ev   = ~sig_in & w_tracking & (r_cnt == HI_LIM);
    assign w_miss_ev   = w_early_ev | w_late_ev;
    assign w_good_inc  = r_good + GOOD_ONE;

    // Next-state and good-interval count.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        case (r_state)
            HUNT: begin
                if (sig_in) begin
                    w_state_nxt = TRACK;
                    w_good_nxt  = '0;
                end else begin
                    w_state_nxt = HUNT;
                end
            end
            TRACK, LOCKED: begin
                if (w_early_ev) begin
                    w_state_nxt = TRACK;
                    w_good_nxt  = '0;
                end else if (w_good_ev) begin
                    if (r_state == LOCKED) begin
                        w_state_nxt = LOCKED;
                    end else if (w_good_inc == GOOD_TARGET) begin
                        w_state_nxt = LOCKED;
                        w_good_nxt  = w_good_inc;
                    end else begin
                        w_state_nxt = TRACK;
                        w_good_nxt  = w_good_inc;
                    end
                end else if (w_late_ev || sig_in) begin
                    w_state_nxt = HUNT;
                    w_good_nxt  = '0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_good_nxt  = '0;
            end
        endcase
    end

    // State, interval counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HUNT;
            r_cnt      <= '0;
            r_good     <= '0;
            r_locked   <= 1'b0;
            r_early    <= 1'b0;
            r_late     <= 1'b0;
            r_err      <= 1'b0;
            r_miss     <= 8'd0;
            r_interval <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_good   <= w_good_nxt;
            r_locked <= (w_state_nxt == LOCKED);
            r_early  <= w_early_ev;
            r_late   <= w_late_ev;
            if (sig_in) begin
                r_cnt <= CNT_ONE;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_pulse_chk) begin
                r_interval <= r_cnt;
            end else begin
                r_interval <= r_interval;
            end
            if (w_miss_ev && (r_miss != 8'hFF)) begin
                r_miss <= r_miss + 8'd1;
            end else begin
                r_miss <= r_miss;
            end
`ifdef PULSE_MON_STICKY_ERR_EN
            r_err <= r_err | w_miss_ev;
`else
            r_err <= w_miss_ev;
`endif
        end
    end

    assign locked   = r_locked;
    assign early    = r_early;
    assign late     = r_late;
    assign err      = r_err;
    assign miss_cnt = r_miss;
    assign interval = r_interval;

endmodule

// File: tb/tb_pulse_period_mon.sv
// Bench for pulse_period_mon: directed scenarios plus random pulse trains, checked every cycle
// against a timestamp-based reference model.
module tb_pulse_period_mon;

    localparam int P  = 10;
    localparam int T  = 1;
    localparam int LN = 3;
    localparam int CB = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          sig_in;
    logic          locked;
    logic          early;
    logic          late;
    logic          err;
    logic [7:0]    miss_cnt;
    logic [CB-1:0] interval;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: timestamps of pulses and a plain mode description.
    int cyc      = 0;
    int m_last   = 0;
    bit m_track  = 1'b0;
    bit m_lk     = 1'b0;
    int m_good   = 0;
    int m_miss   = 0;
    bit m_early  = 1'b0;
    bit m_late   = 1'b0;
    bit m_err    = 1'b0;
    int m_interval = 0;

    always #5 clk = ~clk;

    pulse_period_mon #(.PERIOD(P), .TOL(T), .LOCK_N(LN), .CBITS(CB)) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .locked   (locked),
        .early    (early),
        .late     (late),
        .err      (err),
        .miss_cnt (miss_cnt),
        .interval (interval)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit p, input bit r);
        int  d;
        bit  e;
        bit  l;
        cyc++;
        e = 1'b0;
        l = 1'b0;
        if (r) begin
            m_track = 1'b0; m_lk = 1'b0; m_good = 0; m_miss = 0;
            m_interval = 0; m_err = 1'b0;
        end else begin
            d = cyc - m_last;
            if (p) begin
                if (!m_track) begin
                    m_track = 1'b1; m_good = 0; m_lk = 1'b0;
                end else begin
                    m_interval = d;
                    if (d < P - T) begin
                        e = 1'b1; m_good = 0; m_lk = 1'b0;
                    end else if (!m_lk) begin
                        m_good++;
                        if (m_good == LN) m_lk = 1'b1;
                    end
                end
                m_last = cyc;
            end else if (m_track && d == P + T) begin
                l = 1'b1; m_track = 1'b0; m_lk = 1'b0; m_good = 0;
            end
            if ((e || l) && m_miss < 255) m_miss++;
`ifdef PULSE_MON_STICKY_ERR_EN
            m_err = m_err | e | l;
`else
            m_err = e | l;
`endif
        end
        m_early = e;
        m_late  = l;
    endtask

    task automatic step(input bit p, input bit r);
        sig_in = p;
        rst    = r;
        @(posedge clk);
        model(p, r);
        #1;
        chk("locked",   locked,   m_lk);
        chk("early",    early,    m_early);
        chk("late",     late,     m_late);
        chk("err",      err,      m_err);
        chk("miss_cnt", miss_cnt, m_miss);
        chk("interval", interval, m_interval);
    endtask

    task automatic pulse_iv(input int d);
        step(1'b1, 1'b0);
        repeat (d - 1) step(1'b0, 1'b0);
    endtask

    initial begin
        int k;
        int d;
        sig_in = 1'b0;
        rst    = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_locked", locked, 1'b0);
        chk("rst_miss", miss_cnt, 8'd0);

        // Lock on a clean 10-cycle train.
        repeat (3) pulse_iv(10);
        step(1'b1, 1'b0);
        chk("lock_4th", locked, 1'b1);
        chk("lock_iv10", interval, 10);

        // Early pulse after 7 cycles, then relock.
        repeat (6) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("early7", early, 1'b1);
        chk("early7_unlock", locked, 1'b0);
        chk("early7_miss", miss_cnt, 8'd1);
        repeat (9) step(1'b0, 1'b0);
        repeat (2) pulse_iv(10);
        step(1'b1, 1'b0);
        chk("relock", locked, 1'b1);

        // Pulses stop: late on the cycle after cnt reaches 11.
        repeat (10) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("late_stop", late, 1'b1);
        chk("late_miss", miss_cnt, 8'd2);
        repeat (20) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("hunt_pulse_early", early, 1'b0);
        chk("hunt_pulse_late", late, 1'b0);

        // Boundary intervals 9, 11, 8, 12.
        repeat (8) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("iv9_early", early, 1'b0);
        chk("iv9", interval, 9);
        repeat (10) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("iv11_late", late, 1'b0);
        chk("iv11", interval, 11);
        repeat (7) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("iv8_early", early, 1'b1);
        repeat (10) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("iv12_late", late, 1'b1);
        step(1'b1, 1'b0);

        // Reset mid-interval while locked.
        repeat (9) step(1'b0, 1'b0);
        repeat (3) pulse_iv(10);
        step(1'b1, 1'b0);
        chk("pre_rst_lock", locked, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("midrst_locked", locked, 1'b0);
        chk("midrst_miss", miss_cnt, 8'd0);
        chk("midrst_iv", interval, 0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("post_rst_early", early, 1'b0);
        chk("post_rst_late", late, 1'b0);
        repeat (5) step(1'b0, 1'b0);

        // Random pulse trains with occasional resets.
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 19);
            if (k == 0) begin
                step(1'b0, 1'b1);
            end else begin
                if (k < 10)      d = $urandom_range(9, 11);
                else if (k < 14) d = $urandom_range(1, 8);
                else if (k < 17) d = $urandom_range(12, 30);
                else             d = 10;
                pulse_iv(d);
            end
        end

        // 300 early events back to back: miss_cnt saturates.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (300) begin
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
        chk("sat_miss", miss_cnt, 8'd255);
        chk("sat_err", err, 1'b1);
        step(1'b0, 1'b0);
`ifdef PULSE_MON_STICKY_ERR_EN
        chk("sat_err_hold", err, 1'b1);
`else
        chk("sat_err_hold", err, 1'b0);
`endif
        chk("sat_miss_hold", miss_cnt, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
